mem_bist_ctrl: RTL and testbench

Hardware initiator for the single-port memory interface (addr, wr_en, rd_en, wdata, rdata); it is the requester end of the bus the memory model responds on. On a start pulse it runs a fixed four-phase march test over every address, compares read data against expected values, and reports pass/fail, error count and first failing address. It sits beside the memory in place of the software driver, for built-in self-test.

---
 rtl/mem_bist_ctrl_if.sv | 14 +
 rtl/mem_bist_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_mem_bist_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mem_bist_ctrl_if.sv
// Single-port memory bus between the BIST initiator (master) and the memory (slave).
interface mem_bist_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] addr;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output addr, output wr_en, output rd_en, output wdata, input rdata);
  modport slave  (input addr, input wr_en, input rd_en, input wdata, output rdata);
endinterface

// File: rtl/mem_bist_ctrl.sv
// Four-phase march BIST initiator for a single-port memory with RD_LATENCY-cycle reads.
// Optional MEM_BIST_ERR_STOP_EN: abort to DONE on the first read mismatch.
module mem_bist_ctrl #(
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RD_LATENCY = 1,
  parameter logic [31:0] SEED       = 32'h0000_00A5,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  mem_bist_ctrl_if.master       mem
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ASC  = 3'd1,
    RD_ASC  = 3'd2,
    WR_INV  = 3'd3,
    RD_DESC = 3'd4,
    DRAIN   = 3'd5,
    DONE    = 3'd6
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = {ADDR_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] SEED_W   = DATA_WIDTH'(SEED);

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a,
                                                   input logic inv);
    logic [DATA_WIDTH-1:0] p;
    p = SEED_W ^ DATA_WIDTH'(a);
    return inv ? ~p : p;
  endfunction

  state_t                  state_r, state_nxt;
  logic [ADDR_WIDTH-1:0]   addr_r, addr_nxt;
  logic [2:0]              drain_cnt_r, drain_nxt;
  logic                    wr_en_r, rd_en_r, busy_r, done_r, pass_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic [CNT_WIDTH-1:0]    err_count_r, err_nxt;
  logic [ADDR_WIDTH-1:0]   fail_addr_r, fail_nxt;
  logic                    start_acc_s, mismatch_s;
  logic [DATA_WIDTH-1:0]   exp_s;

  // Expected-data pipeline: one entry per bus cycle, compared when it emerges
  logic [RD_LATENCY-1:0]                 pipe_vld_r;
  logic [RD_LATENCY-1:0][DATA_WIDTH-1:0] pipe_exp_r;
  logic [RD_LATENCY-1:0][ADDR_WIDTH-1:0] pipe_addr_r;

  assign start_acc_s = start && ((state_r == IDLE) || (state_r == DONE));
  assign exp_s       = pattern(addr_r, state_r == RD_DESC);
  assign mismatch_s  = pipe_vld_r[RD_LATENCY-1] && (mem.rdata != pipe_exp_r[RD_LATENCY-1]);

  // Next-state, address sequencing and error bookkeeping
  always_comb begin
    state_nxt = state_r;
    addr_nxt  = addr_r;
    drain_nxt = drain_cnt_r;
    err_nxt   = err_count_r;
    fail_nxt  = fail_addr_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = WR_ASC;
          addr_nxt  = {ADDR_WIDTH{1'b0}};
        end else begin
          state_nxt = state_r;
        end
      end
      WR_ASC, RD_ASC, WR_INV: begin
        if (addr_r == ADDR_MAX) begin
          state_nxt = (state_r == WR_ASC) ? RD_ASC : (state_r == RD_ASC) ? WR_INV : RD_DESC;
          addr_nxt  = (state_r == WR_INV) ? ADDR_MAX : {ADDR_WIDTH{1'b0}};
        end else begin
          addr_nxt = addr_r + ADDR_WIDTH'(1);
        end
      end
      RD_DESC: begin
        if (addr_r == {ADDR_WIDTH{1'b0}}) begin
          state_nxt = DRAIN;
          drain_nxt = 3'd0;
        end else begin
          addr_nxt = addr_r - ADDR_WIDTH'(1);
        end
      end
      DRAIN: begin
        // One extra cycle past the read latency lets the last compare settle before DONE
        if (drain_cnt_r == 3'(RD_LATENCY)) begin
          state_nxt = DONE;
        end else begin
          drain_nxt = drain_cnt_r + 3'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (start_acc_s) begin
      err_nxt  = {CNT_WIDTH{1'b0}};
      fail_nxt = {ADDR_WIDTH{1'b0}};
    end else if (mismatch_s) begin
      err_nxt  = (err_count_r != CNT_MAX) ? err_count_r + CNT_WIDTH'(1) : err_count_r;
      fail_nxt = (err_count_r == {CNT_WIDTH{1'b0}}) ? pipe_addr_r[RD_LATENCY-1] : fail_addr_r;
    end else begin
      err_nxt = err_count_r;
    end

`ifdef MEM_BIST_ERR_STOP_EN
    if (mismatch_s && !start_acc_s) begin
      state_nxt = DONE;
    end else begin
      drain_nxt = drain_nxt;
    end
`endif
  end

  // State, registered bus/status outputs and compare pipeline
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      addr_r      <= {ADDR_WIDTH{1'b0}};
      drain_cnt_r <= 3'd0;
      wr_en_r     <= 1'b0;
      rd_en_r     <= 1'b0;
      wdata_r     <= {DATA_WIDTH{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      err_count_r <= {CNT_WIDTH{1'b0}};
      fail_addr_r <= {ADDR_WIDTH{1'b0}};
      pipe_vld_r  <= {RD_LATENCY{1'b0}};
      pipe_exp_r  <= {(RD_LATENCY*DATA_WIDTH){1'b0}};
      pipe_addr_r <= {(RD_LATENCY*ADDR_WIDTH){1'b0}};
    end else begin
      state_r     <= state_nxt;
      addr_r      <= addr_nxt;
      drain_cnt_r <= drain_nxt;
      wr_en_r     <= (state_nxt == WR_ASC) || (state_nxt == WR_INV);
      rd_en_r     <= (state_nxt == RD_ASC) || (state_nxt == RD_DESC);
      wdata_r     <= ((state_nxt == WR_ASC) || (state_nxt == WR_INV)) ?
                     pattern(addr_nxt, state_nxt == WR_INV) : {DATA_WIDTH{1'b0}};
      busy_r      <= (state_nxt != IDLE) && (state_nxt != DONE);
      done_r      <= (state_nxt == DONE);
      pass_r      <= (state_nxt == DONE) && (err_nxt == {CNT_WIDTH{1'b0}});
      err_count_r <= err_nxt;
      fail_addr_r <= fail_nxt;
      if ((state_nxt == DONE) || (state_nxt == IDLE)) begin
        pipe_vld_r <= {RD_LATENCY{1'b0}};
      end else begin
        pipe_vld_r[0] <= rd_en_r;
        for (int i = 1; i < RD_LATENCY; i++) begin
          pipe_vld_r[i] <= pipe_vld_r[i-1];
        end
      end
      pipe_exp_r[0]  <= exp_s;
      pipe_addr_r[0] <= addr_r;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_exp_r[i]  <= pipe_exp_r[i-1];
        pipe_addr_r[i] <= pipe_addr_r[i-1];
      end
    end
  end

  assign mem.addr  = addr_r;
  assign mem.wr_en = wr_en_r;
  assign mem.rd_en = rd_en_r;
  assign mem.wdata = wdata_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign err_count = err_count_r;
  assign fail_addr = fail_addr_r;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Directed bench: instance A (defaults, 1-cycle memory), instance B (RD_LATENCY=3, CNT_WIDTH=2).
module tb_mem_bist_ctrl;
  logic clk = 1'b0;
  logic reset_a = 1'b0, reset_b = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [7:0] err_a;
  logic [1:0] err_b;
  logic [1:0] fail_a, fail_b;
  int mode_a = 0, mode_b = 0;
  int n_checks = 0, n_fail = 0;
  int overlap_a = 0, overlap_b = 0;
  logic [15:0] wr_log [$];

  always #5 clk = ~clk;

  mem_bist_ctrl_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) if_a ();
  mem_bist_ctrl_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) if_b ();

  mem_bist_ctrl dut_a (.clk(clk), .reset(reset_a), .start(start_a), .busy(busy_a),
                       .done(done_a), .pass(pass_a), .err_count(err_a), .fail_addr(fail_a),
                       .mem(if_a.master));
  mem_bist_ctrl #(.RD_LATENCY(3), .CNT_WIDTH(2)) dut_b (
                       .clk(clk), .reset(reset_b), .start(start_b), .busy(busy_b),
                       .done(done_b), .pass(pass_b), .err_count(err_b), .fail_addr(fail_b),
                       .mem(if_b.master));

  // Memory models: mode 0 clean, 1 = bit0 of address 2 stuck at 0, 2 = rdata stuck at FF
  logic [7:0] mem_a [4];
  logic [7:0] mem_b [4];
  logic [7:0] rq_a, rq_b1, rq_b2, rq_b3;
  always @(posedge clk) begin
    if (if_a.wr_en) mem_a[if_a.addr] <= (mode_a == 1 && if_a.addr == 2'd2) ? (if_a.wdata & 8'hFE) : if_a.wdata;
    if (if_a.rd_en) rq_a <= mem_a[if_a.addr];
    if (if_b.wr_en) mem_b[if_b.addr] <= (mode_b == 1 && if_b.addr == 2'd2) ? (if_b.wdata & 8'hFE) : if_b.wdata;
    rq_b1 <= mem_b[if_b.addr];
    rq_b2 <= rq_b1;
    rq_b3 <= rq_b2;
  end
  assign if_a.rdata = (mode_a == 2) ? 8'hFF : rq_a;
  assign if_b.rdata = (mode_b == 2) ? 8'hFF : rq_b3;

  always @(negedge clk) begin
    if (if_a.wr_en) wr_log.push_back({6'd0, if_a.addr, if_a.wdata});
    if (if_a.wr_en && if_a.rd_en) overlap_a++;
    if (if_b.wr_en && if_b.rd_en) overlap_b++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge (E0); returns just after E0
  task automatic pulse(input bit b);
    @(negedge clk);
    if (b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Count edges after E0 until done is seen; optional extra start pulse at edge 'mid'
  task automatic wait_done(input bit b, input int mid, output int lat);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      start_a = 1'b0;
      start_b = 1'b0;
      if (b ? done_b : done_a) begin
        lat = n;
        break;
      end
      if (n == mid) begin
        if (b) start_b = 1'b1; else start_a = 1'b1;
      end
    end
    if (lat < 0) check_eq("done_timeout", 32'd0, 32'd1);
  endtask

  localparam logic [7:0] WR_EXP [8] = '{8'hA5, 8'hA4, 8'hA7, 8'hA6, 8'h5A, 8'h5B, 8'h58, 8'h59};
  int lat;
  logic [15:0] ent;

  initial begin
    #12;
    check_eq("rst_busy", {31'd0, busy_a}, 32'd0);
    check_eq("rst_done", {31'd0, done_a}, 32'd0);
    check_eq("rst_pass", {31'd0, pass_a}, 32'd0);
    check_eq("rst_err", {24'd0, err_a}, 32'd0);
    check_eq("rst_strobes", {30'd0, if_a.wr_en, if_a.rd_en}, 32'd0);
    check_eq("rst_wdata", {24'd0, if_a.wdata}, 32'd0);
    @(negedge clk);
    reset_a = 1'b1;
    reset_b = 1'b1;

    // Clean run: write sequence, latency 4*4+1+1, pass
    wr_log.delete();
    pulse(1'b0);
    check_eq("busy_after_start", {31'd0, busy_a}, 32'd1);
    wait_done(1'b0, 0, lat);
    check_eq("t1_latency", lat, 32'd18);
    check_eq("t1_pass", {31'd0, pass_a}, 32'd1);
    check_eq("t1_err", {24'd0, err_a}, 32'd0);
    check_eq("t1_fail_addr", {30'd0, fail_a}, 32'd0);
    check_eq("t1_busy_at_done", {31'd0, busy_a}, 32'd0);
    check_eq("t1_nwrites", wr_log.size(), 32'd8);
    for (int i = 0; i < 8 && i < wr_log.size(); i++) begin
      ent = wr_log[i];
      check_eq($sformatf("t1_wr%0d", i), {16'd0, ent}, {22'd0, 2'(i % 4), WR_EXP[i]});
    end

    // Stuck bit at address 2
    mode_a = 1;
    pulse(1'b0);
    wait_done(1'b0, 0, lat);
    check_eq("t2_latency", lat, 32'd18);
    check_eq("t2_err", {24'd0, err_a}, 32'd1);
    check_eq("t2_fail_addr", {30'd0, fail_a}, 32'd2);
    check_eq("t2_pass", {31'd0, pass_a}, 32'd0);

    // Read data stuck at FF
    mode_a = 2;
    pulse(1'b0);
    wait_done(1'b0, 0, lat);
    check_eq("t3_err", {24'd0, err_a}, 32'd8);
    check_eq("t3_fail_addr", {30'd0, fail_a}, 32'd0);
    check_eq("t3_pass", {31'd0, pass_a}, 32'd0);

    // Start held at DONE relaunches and clears results
    mode_a = 0;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    check_eq("t5_done_cleared", {31'd0, done_a}, 32'd0);
    check_eq("t5_err_cleared", {24'd0, err_a}, 32'd0);
    check_eq("t5_busy", {31'd0, busy_a}, 32'd1);
    wait_done(1'b0, 0, lat);
    check_eq("t5_relaunch_latency", lat, 32'd18);
    check_eq("t5_relaunch_pass", {31'd0, pass_a}, 32'd1);

    // Start pulsed while busy is ignored
    pulse(1'b0);
    wait_done(1'b0, 5, lat);
    check_eq("t5_midpulse_latency", lat, 32'd18);

    // Asynchronous reset during RD_ASC
    pulse(1'b0);
    repeat (6) @(posedge clk);
    #3;
    check_eq("t4_in_rd_asc", {31'd0, if_a.rd_en}, 32'd1);
    reset_a = 1'b0;
    #1;
    check_eq("t4_async_addr", {30'd0, if_a.addr}, 32'd0);
    check_eq("t4_async_strobes", {30'd0, if_a.wr_en, if_a.rd_en}, 32'd0);
    check_eq("t4_async_busy_done", {30'd0, busy_a, done_a}, 32'd0);
    @(negedge clk);
    reset_a = 1'b1;
    pulse(1'b0);
    wait_done(1'b0, 0, lat);
    check_eq("t4_rerun_latency", lat, 32'd18);
    check_eq("t4_rerun_pass", {31'd0, pass_a}, 32'd1);

    // Instance B: 3-cycle read latency, 2-bit saturating counter
    pulse(1'b1);
    wait_done(1'b1, 0, lat);
    check_eq("t6_latency", lat, 32'd20);
    check_eq("t6_pass", {31'd0, pass_b}, 32'd1);
    mode_b = 2;
    pulse(1'b1);
    wait_done(1'b1, 0, lat);
    check_eq("t3b_err_sat", {30'd0, err_b}, 32'd3);
    check_eq("t3b_fail_addr", {30'd0, fail_b}, 32'd0);
    check_eq("t3b_pass", {31'd0, pass_b}, 32'd0);

    check_eq("overlap_a", overlap_a, 32'd0);
    check_eq("overlap_b", overlap_b, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
